// File: rtl/ifid_pkg.sv
// rtl/ifid_pkg.sv - shared fetch packet type and NOP constant for the IF/ID buffer
package ifid_pkg;

    localparam int          PKT_XLEN = 32;
    localparam int          OPCODE_W = 7;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [PKT_XLEN-1:0] pc;
        logic [PKT_XLEN-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - elastic IF->ID fetch buffer with flush; optional same-cycle bypass via IFID_BYPASS_EN
module if_id_buffer
    import ifid_pkg::*;
#(
    parameter int XLEN  = PKT_XLEN,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic [OPCODE_W-1:0]      out_opcode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_pkt_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic       empty;
    logic       full;
    logic       bypass;
    logic       push;
    logic       pop_mem;
    fetch_pkt_t head;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

    always_comb begin
        head   = mem[rd_ptr];
        bypass = 1'b0;
`ifdef IFID_BYPASS_EN
        // Empty buffer: forward the incoming packet straight to ID this cycle
        if (empty && in_valid && !flush) begin
            bypass    = 1'b1;
            head.pc   = in_pc;
            head.inst = in_inst;
        end
`endif
    end

    // Flush masks out_valid so ID never consumes a wrong-path instruction
    assign out_valid  = !flush && (!empty || bypass);
    assign out_pc     = out_valid ? head.pc   : '0;
    assign out_inst   = out_valid ? head.inst : NOP_INST;
    assign out_opcode = out_inst[OPCODE_W-1:0];

    // A bypassed packet consumed the same cycle never touches storage
    assign push    = in_valid && in_ready && !flush && !(bypass && out_ready);
    assign pop_mem = out_valid && out_ready && !bypass;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_mem) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop_mem})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - scoreboard bench for if_id_buffer (default build, bypass disabled)
module tb_if_id_buffer;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [6:0]  out_opcode;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    logic [63:0] exp_q [$];

    if_id_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_opcode(out_opcode), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return {pc[24:0], 7'b0110011};
    endfunction

    // Monitor: every consumed packet must match the oldest expected one
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            logic [63:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %0h inst %0h with nothing expected", out_pc, out_inst);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", 64'(out_pc), 64'(e[63:32]));
                check("sb_inst", 64'(out_inst), 64'(e[31:0]));
                check("sb_opcode", 64'(out_opcode), 64'(e[6:0]));
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, output logic acc);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = mk_inst(pc);
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        check("count", 64'(count), 64'(mcount));
        check("in_ready", 64'(in_ready), 64'(mcount < DEPTH));
        check("out_valid", 64'(out_valid), 64'(!fl && mcount > 0));
        if (fl || mcount == 0) begin
            check("idle_inst", 64'(out_inst), 64'(NOP));
            check("idle_pc", 64'(out_pc), 64'h0);
            check("idle_opcode", 64'(out_opcode), 64'(7'b0010011));
        end
        acc = v && (mcount < DEPTH) && !fl;
        if (fl) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            if (mcount > 0 && rdy) mcount--;
            if (acc) begin
                exp_q.push_back({pc, mk_inst(pc)});
                mcount++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic a;
        for (int c = 0; c < 8 && mcount > 0; c++) step(1'b0, 32'h0, 1'b1, 1'b0, a);
        check("drained", 64'(mcount), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a;
        logic [31:0] pcs [4];
        int          idx;

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_inst", 64'(out_inst), 64'(NOP));
        check("rst_out_pc", 64'(out_pc), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_count", 64'(count), 64'h0);
        rstn = 1'b1;

        // Single push, visible next cycle
        step(1'b1, 32'h0, 1'b1, 1'b0, a);
        step(1'b0, 32'h0, 1'b1, 1'b0, a);
        step(1'b0, 32'h0, 1'b1, 1'b0, a);

        // ID stall with continuous fetch; refused packets are re-offered
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
        idx = 0;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            step(1'b1, pcs[idx], c >= 5, 1'b0, a);
            if (a) idx++;
        end
        check("stall_all_sent", 64'(idx), 64'd4);
        drain();

        // Flush with two buffered entries and a packet on the input
        step(1'b1, 32'h100, 1'b0, 1'b0, a);
        step(1'b1, 32'h104, 1'b0, 1'b0, a);
        step(1'b1, 32'h40, 1'b1, 1'b1, a);
        step(1'b0, 32'h0, 1'b1, 1'b0, a);
        step(1'b1, 32'h200, 1'b1, 1'b0, a);
        drain();

        // Back-to-back flow through wrapping pointers
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, a);
        drain();

        // Asynchronous reset while holding two entries
        step(1'b1, 32'h300, 1'b0, 1'b0, a);
        step(1'b1, 32'h304, 1'b0, 1'b0, a);
        check("pre_rst_count", 64'(count), 64'd2);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'h0);
        check("arst_out_inst", 64'(out_inst), 64'(NOP));
        check("arst_count", 64'(count), 64'h0);
        check("arst_in_ready", 64'(in_ready), 64'h1);
        mcount = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b1, 32'h400, 1'b1, 1'b0, a);
        drain();

        // Empty and idle: NOP constant held
        for (int i = 0; i < 5; i++) step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, a);

        check("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
